// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int unsigned C_WORD_W      = 32;
    localparam int unsigned C_BYTE_STRIDE = 4;
    localparam int unsigned C_COUNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    // Byte address of word number idx in an image starting at base.
    function automatic logic [C_WORD_W-1:0] word_addr(
        input logic [C_WORD_W-1:0]  base,
        input logic [C_COUNT_W-1:0] idx
    );
        return base + (C_WORD_W'(idx) * C_WORD_W'(C_BYTE_STRIDE));
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_hold_ctr.sv
// ============================================================================
// Module      : imem_loader_hold_ctr
// Description : Loadable down-counter; o_end flags the last cycle of a hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader_hold_ctr #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_end
);

    localparam int unsigned C_CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [C_CW-1:0] c_reload = C_CW'(HOLD_CYCLES - 1);

    logic [C_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_reload;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_end = i_en && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Streams instruction words into CPU instruction memory, then
//               releases the CPU from reset. Optional: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd0,
    parameter int unsigned MAX_WORDS   = 64,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_address,
    output logic [31:0] instruction_initialize_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        overflow,
    output logic [15:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam logic [C_COUNT_W-1:0] c_max_words = C_COUNT_W'(MAX_WORDS);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_last;
    logic                 w_accept;
    logic                 w_start_ok;
    logic                 w_hold_end;
    logic [C_COUNT_W-1:0] w_count_inc;
    logic                 w_full;

    // in_ready is registered and only ever high in LOAD, so it qualifies the handshake.
    assign w_accept    = (r_state == ST_LOAD) && in_valid && in_ready;
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_count_inc = word_count + 1'b1;
    assign w_full      = (w_count_inc == c_max_words);

    imem_loader_hold_ctr #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_en   (r_state == ST_WRITE),
        .o_end  (w_hold_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_LOAD;
            ST_LOAD:    if (w_accept) w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (w_hold_end) begin
                    w_state_next = (r_last || w_full) ? ST_RELEASE : ST_LOAD;
                end
            end
            ST_RELEASE: w_state_next = ST_RUN;
            ST_RUN:     if (start) w_state_next = ST_LOAD;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready                       <= 1'b0;
            initialize                     <= 1'b1;
            cpu_rst                        <= 1'b1;
            done                           <= 1'b0;
            overflow                       <= 1'b0;
            word_count                     <= '0;
            instruction_initialize_address <= BASE_ADDR;
            instruction_initialize_data    <= '0;
            r_last                         <= 1'b0;
        end else begin
            in_ready   <= (w_state_next == ST_LOAD);
            initialize <= (w_state_next != ST_RUN);
            cpu_rst    <= (w_state_next != ST_RUN);
            done       <= (w_state_next == ST_RUN);
            if (w_start_ok) begin
                word_count <= '0;
                overflow   <= 1'b0;
            end
            if (w_accept) begin
                instruction_initialize_data    <= in_data;
                instruction_initialize_address <= word_addr(BASE_ADDR, word_count);
                r_last                         <= in_last;
            end
            if ((r_state == ST_WRITE) && w_hold_end) begin
                word_count <= w_count_inc;
                if (!r_last && w_full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (w_start_ok) begin
            checksum <= '0;
        end else if (w_accept) begin
            checksum <= checksum ^ in_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (scoreboard of expected
//               memory writes). Honours IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam logic [31:0] BASE = 32'd0;
    localparam int          HOLD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, initialize, cpu_rst, done, overflow;
    logic [31:0] ia, id;
    logic [15:0] word_count;

    logic        start2 = 1'b0, in_valid2 = 1'b0, in_last2 = 1'b0;
    logic [31:0] in_data2 = '0;
    logic        in_ready2, initialize2, cpu_rst2, done2, overflow2;
    logic [31:0] ia2, id2;
    logic [15:0] word_count2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum, checksum2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_idx  = 0;

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(64), .HOLD_CYCLES(HOLD)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .initialize(initialize),
        .instruction_initialize_address(ia), .instruction_initialize_data(id),
        .cpu_rst(cpu_rst), .done(done), .overflow(overflow), .word_count(word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(4), .HOLD_CYCLES(HOLD)) u_dut_ovf (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
        .in_last(in_last2), .in_ready(in_ready2), .initialize(initialize2),
        .instruction_initialize_address(ia2), .instruction_initialize_data(id2),
        .cpu_rst(cpu_rst2), .done(done2), .overflow(overflow2), .word_count(word_count2)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(checksum2)
`endif
    );

    // Scoreboard of expected writes to the main DUT
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t         sb_q[$];
    wr_t         cur;
    bit          acc_flag = 1'b0;
    bit          rst_flag = 1'b1;
    int          hold_left = 0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) begin
        acc_flag = in_valid && (in_ready === 1'b1) && !rst;
        rst_flag = rst;
    end

    always @(negedge clk) begin
        if (rst_flag) begin
            hold_left = 0;
        end else if (acc_flag) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_write: address=%h, required no write", ia);
            end else begin
                cur = sb_q.pop_front();
                hold_left = HOLD;
            end
        end else if (hold_left == 0 && ia !== prev_addr) begin
            n_checks++; n_errors++;
            $display("FAIL spurious_write: address=%h, required %h", ia, prev_addr);
        end
        if (hold_left > 0) begin
            n_checks++;
            if (ia !== cur.a || id !== cur.d || initialize !== 1'b1) begin
                n_errors++;
                $display("FAIL write_hold: addr=%h data=%h init=%b, required %h %h 1",
                         ia, id, initialize, cur.a, cur.d);
            end
            hold_left--;
        end
        prev_addr = ia;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_idx = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            sb_q.push_back('{BASE + 32'(exp_idx * 4), d});
            exp_idx++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL done_timeout: done=%b, required 1", done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (initialize !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle: init=%b cpu_rst=%b in_ready=%b done=%b, required 1 1 0 0",
                         initialize, cpu_rst, in_ready, done);
            end
            @(negedge clk);
        end
        n_checks++;
        if (ia !== BASE || id !== 32'd0 || word_count !== 16'd0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs: addr=%h data=%h count=%0d ovf=%b, required %h 0 0 0",
                     ia, id, word_count, overflow, BASE);
        end
    endtask

    task automatic test_load_11();
        pulse_start();
        for (int i = 0; i < 11; i++) send_word(32'h0002_2020 + 32'(i * 256), (i == 10));
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            n_errors++;
            $display("FAIL release_cycle: done=%b cpu_rst=%b, required 0 1", done, cpu_rst);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || initialize !== 1'b0) begin
            n_errors++;
            $display("FAIL run_entry: done=%b cpu_rst=%b init=%b, required 1 0 0", done, cpu_rst, initialize);
        end
        n_checks++;
        if (word_count !== 16'd11 || overflow !== 1'b0 || ia !== 32'd40 || id !== 32'h0002_2A20) begin
            n_errors++;
            $display("FAIL load_11_final: count=%0d ovf=%b addr=%h data=%h, required 11 0 28 00022a20",
                     word_count, overflow, ia, id);
        end
    endtask

    task automatic test_gap();
        pulse_start();
        n_checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || initialize !== 1'b1 || cpu_rst !== 1'b1 || word_count !== 16'd0) begin
            n_errors++;
            $display("FAIL restart: ready=%b done=%b init=%b cpu_rst=%b count=%0d, required 1 0 1 1 0",
                     in_ready, done, initialize, cpu_rst, word_count);
        end
        for (int i = 0; i < 3; i++) send_word(32'h1111_0000 + 32'(i), 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (in_ready !== 1'b1 || ia !== 32'd8) begin
                n_errors++;
                $display("FAIL gap_wait: ready=%b addr=%h, required 1 8", in_ready, ia);
            end
            @(negedge clk);
        end
        send_word(32'h1111_0003, 1'b1);
        wait_done();
        n_checks++;
        if (word_count !== 16'd4 || ia !== 32'd12) begin
            n_errors++;
            $display("FAIL gap_final: count=%0d addr=%h, required 4 c", word_count, ia);
        end
    endtask

    task automatic test_overflow();
        int          acc = 0;
        bit          pend = 1'b0;
        logic [31:0] exp_a = '0, exp_d = '0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        in_valid2 = 1'b1;
        in_data2  = 32'hA000_0000;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (in_ready2 === 1'b1 && in_valid2) begin
                exp_a = 32'(acc * 4); exp_d = in_data2; acc++; pend = 1'b1;
            end
            @(negedge clk);
            if (pend) begin
                n_checks++;
                if (ia2 !== exp_a || id2 !== exp_d) begin
                    n_errors++;
                    $display("FAIL ovf_write: addr=%h data=%h, required %h %h", ia2, id2, exp_a, exp_d);
                end
                pend = 1'b0;
                in_data2 = 32'hA000_0000 + 32'(acc);
            end
            if (acc >= 6) in_valid2 = 1'b0;
        end
        in_valid2 = 1'b0;
        n_checks++;
        if (acc !== 4 || overflow2 !== 1'b1 || word_count2 !== 16'd4 || done2 !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow: accepted=%0d ovf=%b count=%0d done=%b, required 4 1 4 1",
                     acc, overflow2, word_count2, done2);
        end
    endtask

    task automatic test_rst_mid();
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(32'h2222_0000 + 32'(i), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (ia !== BASE || id !== 32'd0 || word_count !== 16'd0 || in_ready !== 1'b0 ||
            initialize !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: addr=%h data=%h count=%0d ready=%b init=%b cpu_rst=%b done=%b ovf=%b, required reset values",
                     ia, id, word_count, in_ready, initialize, cpu_rst, done, overflow);
        end
        repeat (2) @(negedge clk);
        pulse_start();
        send_word(32'h3333_0000, 1'b1);
        wait_done();
        n_checks++;
        if (word_count !== 16'd1 || ia !== BASE) begin
            n_errors++;
            $display("FAIL rst_reload: count=%0d addr=%h, required 1 %h", word_count, ia, BASE);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        send_word(32'h4, 1'b1);
        wait_done();
        n_checks++;
        if (checksum !== 32'h7) begin
            n_errors++;
            $display("FAIL checksum_run: checksum=%h, required 7", checksum);
        end
        pulse_start();
        n_checks++;
        if (checksum !== 32'h0) begin
            n_errors++;
            $display("FAIL checksum_clear: checksum=%h, required 0", checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_11();
        test_gap();
        test_overflow();
        test_rst_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Program loader sitting directly upstream of the single-cycle `cpu`: drives its `initialize`, `instruction_initialize_address`, `instruction_initialize_data` and `rst` inputs. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into consecutive word addresses of instruction memory, holding each write stable for a programmable number of cycles. After the last word it releases the CPU from reset and flags completion. It replaces hand-timed testbench loading in system-level benches and on-board boot.

## Interface
- `BASE_ADDR`, 0: byte address of the first instruction word (multiple of 4).
- `MAX_WORDS`, 64: image size limit in words (1..65535).
- `HOLD_CYCLES`, 2: cycles each address/data pair is held with `initialize`=1 (≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  pulse; begins a load from IDLE or RUN.
- `in_valid`  in  1  instruction word present.
- `in_data`  in  32  instruction word.
- `in_last`  in  1  qualifies final word of image.
- `in_ready`  out  1  loader accepts a word this cycle.
- `initialize`  out  1  to `cpu.initialize`.
- `instruction_initialize_address`  out  32  byte address to `cpu`.
- `instruction_initialize_data`  out  32  word to `cpu`.
- `cpu_rst`  out  1  to `cpu.rst`.
- `done`  out  1  image loaded, CPU running.
- `overflow`  out  1  image truncated at `MAX_WORDS` without `in_last`.
- `word_count`  out  16  words written this load.

## Operation
- States: IDLE, LOAD, WRITE, RELEASE, RUN.
- Reset: state IDLE; `in_ready`=0, `initialize`=1, `cpu_rst`=1, address=`BASE_ADDR`, data=0, `done`=0, `overflow`=0, `word_count`=0.
- IDLE: `initialize`=1, `cpu_rst`=1; `start` → LOAD.
- LOAD: `in_ready`=1. On `in_valid`&&`in_ready`: data register ← `in_data`, address ← `BASE_ADDR` + 4·`word_count`, latch `in_last` → WRITE.
- WRITE: `in_ready`=0; hold counter runs `HOLD_CYCLES` cycles; on final cycle `word_count`+1. Then: latched last → RELEASE; new count == `MAX_WORDS` → RELEASE with `overflow`=1; else → LOAD.
- RELEASE: single cycle; `initialize` and `cpu_rst` deasserted on the same edge; → RUN.
- RUN: `done`=1, `initialize`=0, `cpu_rst`=0, outputs frozen at last write. `start` → LOAD with `initialize`=1, `cpu_rst`=1, `done`=0, `overflow`=0, `word_count`=0 on the same edge.
- `start` in LOAD/WRITE/RELEASE ignored. `in_valid` outside LOAD ignored (not consumed).
- Address arithmetic: 32-bit, wraps modulo 2^32; no check.
- `rst` mid-load: immediate return to reset values; words already written remain in CPU memory; next load restarts at `BASE_ADDR`.

## Timing
- Handshake accepted at edge N → address/data valid from N+1 through N+`HOLD_CYCLES`, `initialize`=1 throughout.
- `in_ready` reasserts at N+`HOLD_CYCLES`+1; peak rate one word per `HOLD_CYCLES`+1 cycles.
- Last word accepted at edge N → RELEASE at N+`HOLD_CYCLES`+1, `cpu_rst`=0 and `done`=1 from N+`HOLD_CYCLES`+2.
- `start`→`in_ready`: one cycle. All outputs registered.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: adds output `checksum` (32 bits), XOR of all accepted words, cleared on reset and on `start`, stable in RUN.
- Undefined: no `checksum` port, no accumulator logic; all other behaviour identical.

## Structure
- Package `imem_loader_pkg`: state enum (IDLE, LOAD, WRITE, RELEASE, RUN), word width 32, byte stride 4, count width 16.
- One sub-module natural: `imem_loader_hold_ctr`, loadable down-counter producing the end-of-hold pulse.

## Test plan
- Reset, no `start` for 10 cycles → `initialize`=1, `cpu_rst`=1, `in_ready`=0, `done`=0 every cycle.
- `start`, 11 words 0x00022020… back-to-back, last on word 11, `HOLD_CYCLES`=2 → addresses 0,4,…,40 each held 2 cycles; `done`=1, `word_count`=11, `overflow`=0.
- `in_valid` deasserted 5 cycles between words 3 and 4 → `in_ready` stays 1, address 12 written only once word 4 arrives; no duplicate writes.
- `MAX_WORDS`=4, 6 words without `in_last` → 4 writes (0..12), `overflow`=1, words 5–6 never get `in_ready`.
- `rst` during 3rd word's WRITE → next cycle reset values; new `start` writes first word at `BASE_ADDR`.
- With `IMEM_LOADER_CHECKSUM_EN`: words 0x1, 0x2, 0x4 → `checksum`=0x7 in RUN; second `start` clears it to 0.
